// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg: shared FSM state type and default geometry for the LCD serial port
package lcd_spi_pkg;
  localparam int LCD_SPI_CLK_DIV = 2;
  localparam int LCD_SPI_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} spi_state_t;
endpackage

// File: rtl/lcd_spi_sck_div.sv
// lcd_spi_sck_div: phase counter for one SCK half-period with terminal-count flag
module lcd_spi_sck_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic [$clog2(CLK_DIV+1)-1:0] cnt,
  output logic phase_end
);
  localparam int CW = $clog2(CLK_DIV + 1);
  assign phase_end = cnt == CW'(CLK_DIV - 1);
  // Counts 0..CLK_DIV-1 and restarts on every phase change; held at 0 while idle
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || phase_end) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: SPI mode-0 byte transmitter for the LCD panel with burst chip-select
module lcd_spi_tx
  import lcd_spi_pkg::*;
#(
  parameter int CLK_DIV = LCD_SPI_CLK_DIV,
  parameter int DATA_W = LCD_SPI_DATA_W
) (
  input  logic CLKI,
  input  logic RST,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic TX_DC,
  input  logic TX_VALID,
  output logic TX_READY,
  output logic SCK,
  output logic MOSI,
  output logic CS_N,
  output logic DC,
  output logic BUSY
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W);
  spi_state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic phase_end, accept, last_bit, ready_d;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0] bit_cnt;
  logic sck_q, mosi_q, cs_n_q, dc_q, ready_q;
  assign accept = TX_VALID && ready_q;
  assign last_bit = bit_cnt == BW'(DATA_W - 1);
  assign TX_READY = ready_q;
  assign SCK = sck_q;
  assign MOSI = mosi_q;
  assign CS_N = cs_n_q;
  assign DC = dc_q;
  assign BUSY = ~cs_n_q;
  lcd_spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(CLKI),
    .rst(RST),
    .clr(state == IDLE),
    .cnt(cnt),
    .phase_end(phase_end)
  );
  // State register
  always_ff @(posedge CLKI or posedge RST)
    if (RST) state <= IDLE;
    else state <= nstate;
  // Next state; ready is precomputed so it is high exactly in IDLE and the last HOLD cycle
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = accept ? SETUP : IDLE;
      SETUP:   nstate = phase_end ? HIGH : SETUP;
      HIGH:    nstate = !phase_end ? HIGH : last_bit ? HOLD : SETUP;
      HOLD:    nstate = !phase_end ? HOLD : accept ? SETUP : IDLE;
      default: nstate = IDLE;
    endcase
    ncnt = (state == IDLE || phase_end) ? '0 : cnt + CW'(1);
    ready_d = nstate == IDLE || (nstate == HOLD && ncnt == CW'(CLK_DIV - 1));
  end
  // Shift register and registered serial outputs, updated at phase boundaries
  always_ff @(posedge CLKI or posedge RST)
    if (RST) begin
      ready_q <= 1'b0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      dc_q <= 1'b0;
      sh <= '0;
      bit_cnt <= '0;
    end else begin
      ready_q <= ready_d;
      if (accept) begin
        sh <= TX_DATA;
        mosi_q <= TX_DATA[DATA_W-1];
        dc_q <= TX_DC;
        cs_n_q <= 1'b0;
        bit_cnt <= '0;
      end else if (phase_end && state == SETUP) sck_q <= 1'b1;
      else if (phase_end && state == HIGH) begin
        sck_q <= 1'b0;
        if (!last_bit) begin
          sh <= sh << 1;
          mosi_q <= sh[DATA_W-2];
          bit_cnt <= bit_cnt + BW'(1);
        end
      end else if (phase_end && state == HOLD) begin
        cs_n_q <= 1'b1;
        mosi_q <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb_lcd_spi_tx: directed and random bytes on CLK_DIV=2 and CLK_DIV=1 instances against a timing-formula model
module tb_lcd_spi_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][7:0] tx_data;
  logic [1:0] tx_dc, tx_valid, tx_ready, sck, mosi, cs_n, dc, busy;
  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int esr = 0;
  int t_last[2];
  logic [7:0] byte_q[2];
  logic exp_dc[2];
  logic acc[2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    lcd_spi_tx #(.CLK_DIV(g == 0 ? 2 : 1), .DATA_W(8)) u_dut (
      .CLKI(clk), .RST(rst), .TX_DATA(tx_data[g]), .TX_DC(tx_dc[g]), .TX_VALID(tx_valid[g]),
      .TX_READY(tx_ready[g]), .SCK(sck[g]), .MOSI(mosi[g]), .CS_N(cs_n[g]), .DC(dc[g]), .BUSY(busy[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vec++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  // One cycle: compare both instances at the falling edge, log handshakes, advance past the rising edge
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      int d;
      int rel;
      logic low;
      logic eb;
      d = (g == 0) ? 2 : 1;
      rel = cyc - t_last[g] - 1;
      if (rst) begin
        chk($sformatf("i%0d_reset", g), {26'd0, sck[g], mosi[g], cs_n[g], dc[g], busy[g], tx_ready[g]}, 32'b001000);
        t_last[g] = -1;
        exp_dc[g] = 1'b0;
        acc[g] = 1'b0;
      end else begin
        low = t_last[g] >= 0 && rel >= 0 && rel < 17 * d;
        eb = !low ? 1'b0 : rel < 16 * d ? byte_q[g][3'(7 - rel / (2 * d))] : byte_q[g][0];
        chk($sformatf("i%0d_cs_n@%0d", g, cyc), 32'(cs_n[g]), 32'(!low));
        chk($sformatf("i%0d_busy@%0d", g, cyc), 32'(busy[g]), 32'(low));
        chk($sformatf("i%0d_ready@%0d", g, cyc), 32'(tx_ready[g]),
            32'(esr >= 1 && (t_last[g] < 0 || rel >= 17 * d - 1)));
        chk($sformatf("i%0d_dc@%0d", g, cyc), 32'(dc[g]), 32'(exp_dc[g]));
        chk($sformatf("i%0d_sck@%0d", g, cyc), 32'(sck[g]), 32'(low && rel < 16 * d && (rel / d) % 2 == 1));
        chk($sformatf("i%0d_mosi@%0d", g, cyc), 32'(mosi[g]), 32'(eb));
        acc[g] = tx_ready[g] && tx_valid[g];
        if (acc[g]) begin
          t_last[g] = cyc;
          byte_q[g] = tx_data[g];
          exp_dc[g] = tx_dc[g];
        end
      end
    end
    @(posedge clk);
    esr = rst ? 0 : esr + 1;
    #1;
    cyc++;
  endtask
  task automatic send(input int g, input logic [7:0] b, input logic d);
    int k;
    k = 0;
    tx_data[g] = b;
    tx_dc[g] = d;
    tx_valid[g] = 1'b1;
    do begin
      tick();
      k++;
    end while (!acc[g] && k < 200);
    chk($sformatf("i%0d_accept_%0h", g, b), 32'(acc[g]), 32'd1);
    tx_valid[g] = 1'b0;
    tx_data[g] = 8'($urandom);
    tx_dc[g] = 1'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      tx_data[0] = 8'($urandom);
      tx_data[1] = 8'($urandom);
      tick();
    end
  endtask
  initial begin
    int n_fall;
    int t0;
    t_last = '{-1, -1};
    exp_dc = '{1'b0, 1'b0};
    acc = '{1'b0, 1'b0};
    tx_data = '0;
    tx_dc = '0;
    tx_valid = '0;
    tx_data[0] = 8'h5A;
    tx_dc[0] = 1'b1;
    tx_valid[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_fall = cyc;
    send(0, 8'h5A, 1'b1);
    chk("i0_first_accept", 32'(t_last[0]), 32'(n_fall + 1));
    idle(40);
    send(0, 8'hA5, 1'b0);
    idle(40);
    send(0, 8'h2C, 1'b0);
    t0 = t_last[0];
    send(0, 8'h55, 1'b1);
    chk("i0_burst_spacing", 32'(t_last[0] - t0), 32'd34);
    idle(40);
    send(0, 8'h11, 1'b0);
    t0 = t_last[0];
    idle(10);
    send(0, 8'h3C, 1'b1);
    chk("i0_midxfer_accept", 32'(t_last[0] - t0), 32'd34);
    idle(40);
    send(0, 8'hFF, 1'b0);
    idle(11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);
    send(0, 8'h81, 1'b1);
    idle(40);
    for (int i = 0; i < 20; i++) begin
      send(0, 8'($urandom), 1'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(40);
    send(1, 8'h01, 1'b0);
    idle(20);
    for (int i = 0; i < 10; i++) begin
      send(1, 8'($urandom), 1'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(40);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
